// File: rtl/tof_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master port among N_REQ ToF sequencers.
// Define TOF_ARB_TIMEOUT_EN to build the per-transaction watchdog.
module tof_i2c_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_start,
    input  logic [N_REQ-1:0]      req_is_read,
    input  logic [16*N_REQ-1:0]   req_addr,
    input  logic [10*N_REQ-1:0]   req_nb_bytes,
    input  logic [8*N_REQ-1:0]    req_wdata,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      error,
    output logic [7:0]            rdata,
    output logic                  busy,
    output logic                  timeout,
    output logic                  m_start,
    output logic [15:0]           m_register_address,
    output logic                  m_is_read,
    output logic [9:0]            m_nb_of_bytes,
    output logic [7:0]            m_i2c_data,
    input  logic                  m_ready,
    input  logic                  m_error,
    input  logic [7:0]            m_rdata
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WACC,
        S_WDONE,
        S_REL
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N_REQ-1:0]   r_pending;
    logic [N_REQ-1:0]   r_grant;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_gidx;
    logic               r_err;
    logic               r_to;
    logic               r_mstart;
    logic [15:0]        r_addr;
    logic               r_rd;
    logic [9:0]         r_nb;
    logic [7:0]         r_wd;
    logic [7:0]         r_rdata;

    logic [N_REQ-1:0]   w_set;
    logic [N_REQ-1:0]   w_win_oh;
    logic [IW-1:0]      w_win;
    logic               w_found;
    int                 w_idx;
    logic [15:0]        w_addr;
    logic               w_rd;
    logic [9:0]         w_nb;
    logic [7:0]         w_wd;
    logic               w_wait;
    logic               w_to_hit;

    // Search begins just after the last served index and wraps.
    always_comb begin
        w_set   = r_pending | req_start;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_last) + 1 + k) % N_REQ;
            if (!w_found && w_set[w_idx]) begin
                w_found = 1'b1;
                w_win   = IW'(w_idx);
            end
        end
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
    end

    always_comb begin
        w_addr = '0;
        w_rd   = 1'b0;
        w_nb   = '0;
        w_wd   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_addr = req_addr[16*i +: 16];
                w_rd   = req_is_read[i];
                w_nb   = req_nb_bytes[10*i +: 10];
                w_wd   = req_wdata[8*i +: 8];
            end
        end
    end

    assign w_wait = (r_state == S_WACC) || (r_state == S_WDONE);

`ifdef TOF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wdog;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (w_wait) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_to_hit = w_wait && (r_wdog == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: if (m_ready) w_next = S_WACC;
            S_WACC: begin
                if (w_to_hit)      w_next = S_REL;
                else if (!m_ready) w_next = S_WDONE;
            end
            S_WDONE: if (m_ready || w_to_hit) w_next = S_REL;
            S_REL:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_grant   <= '0;
            r_last    <= IW'(N_REQ - 1);
            r_gidx    <= '0;
            r_err     <= 1'b0;
            r_to      <= 1'b0;
            r_mstart  <= 1'b0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_nb      <= '0;
            r_wd      <= '0;
            r_rdata   <= '0;
        end else begin
            r_state  <= w_next;
            r_mstart <= (r_state == S_ISSUE) && m_ready;
            if (r_state == S_IDLE) begin
                r_pending <= w_set & ~w_win_oh;
            end else begin
                r_pending <= r_pending | req_start;
            end
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_win_oh;
                r_gidx  <= w_win;
                r_addr  <= w_addr;
                r_rd    <= w_rd;
                r_nb    <= w_nb;
                r_wd    <= w_wd;
                r_err   <= 1'b0;
                r_to    <= 1'b0;
            end
            // A master completion wins over a watchdog hit in the same cycle.
            if (r_state == S_WDONE && m_ready) begin
                r_err <= m_error;
                if (r_rd) r_rdata <= m_rdata;
            end else if (w_to_hit) begin
                r_err <= 1'b1;
                r_to  <= 1'b1;
            end
            if (r_state == S_REL) begin
                r_grant <= '0;
                r_last  <= r_gidx;
            end
        end
    end

    assign grant              = r_grant;
    assign done               = (r_state == S_REL && !r_err) ? r_grant : '0;
    assign error              = (r_state == S_REL && r_err) ? r_grant : '0;
    assign timeout            = (r_state == S_REL) && r_to;
    assign busy               = (r_state != S_IDLE);
    assign rdata              = r_rdata;
    assign m_start            = r_mstart;
    assign m_register_address = r_addr;
    assign m_is_read          = r_rd;
    assign m_nb_of_bytes      = r_nb;
    assign m_i2c_data         = r_wd;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Directed and randomized bench for tof_i2c_arbiter with a transaction-level
// round-robin model and a responder standing in for the I2C master.
module tb_tof_i2c_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_start;
    logic [N-1:0]  req_is_read;
    logic [16*N-1:0] req_addr;
    logic [10*N-1:0] req_nb_bytes;
    logic [8*N-1:0]  req_wdata;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [N-1:0]  error;
    logic [7:0]    rdata;
    logic          busy;
    logic          timeout;
    logic          m_start;
    logic [15:0]   m_register_address;
    logic          m_is_read;
    logic [9:0]    m_nb_of_bytes;
    logic [7:0]    m_i2c_data;
    logic          m_ready;
    logic          m_error;
    logic [7:0]    m_rdata;

    tof_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .reset(reset),
        .req_start(req_start),
        .req_is_read(req_is_read),
        .req_addr(req_addr),
        .req_nb_bytes(req_nb_bytes),
        .req_wdata(req_wdata),
        .grant(grant),
        .done(done),
        .error(error),
        .rdata(rdata),
        .busy(busy),
        .timeout(timeout),
        .m_start(m_start),
        .m_register_address(m_register_address),
        .m_is_read(m_is_read),
        .m_nb_of_bytes(m_nb_of_bytes),
        .m_i2c_data(m_i2c_data),
        .m_ready(m_ready),
        .m_error(m_error),
        .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [15:0] p_addr [N];
    logic        p_rd   [N];
    logic [9:0]  p_nb   [N];
    logic [7:0]  p_wd   [N];

    // Master responder controls
    bit          mst_rand = 0;
    bit          mst_hold = 0;
    bit          mst_err  = 0;
    int          mst_lat  = 0;
    logic [7:0]  mst_rd   = 8'h00;
    bit          mst_fire = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(int i, logic rd, logic [15:0] a,
                           logic [9:0] nb, logic [7:0] wd);
        p_addr[i] = a;
        p_rd[i]   = rd;
        p_nb[i]   = nb;
        p_wd[i]   = wd;
        req_is_read[i]          = rd;
        req_addr[16*i +: 16]    = a;
        req_nb_bytes[10*i +: 10] = nb;
        req_wdata[8*i +: 8]     = wd;
    endtask

    task automatic wait_fire(string tag);
        int c;
        c = 0;
        while (mst_fire !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_fire"}, 32'(mst_fire), 1);
    endtask

    task automatic wait_idle(string tag);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    function automatic int rr(logic [N-1:0] s, int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (s[j]) return j;
        end
        return -1;
    endfunction

    function automatic int oh2i(logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    // I2C master stand-in: accepts m_start, stays busy, then completes.
    initial begin
        int         lat;
        bit         e;
        logic [7:0] d;
        m_ready = 1'b1;
        m_error = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                if (mst_rand) begin
                    lat = $urandom_range(0, 4);
                    e   = ($urandom_range(0, 4) == 0);
                    d   = 8'($urandom);
                end else begin
                    lat = mst_lat;
                    e   = mst_err;
                    d   = mst_rd;
                end
                @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (lat) @(posedge clk);
                while (mst_hold) @(posedge clk);
                @(posedge clk);
                #1;
                m_ready  = 1'b1;
                m_error  = e;
                m_rdata  = d;
                mst_fire = 1;
                @(posedge clk);
                #1;
                m_error  = 1'b0;
                m_rdata  = 8'($urandom);
                mst_fire = 0;
            end
        end
    end

    initial begin
        int         ord [5];
        int         got;
        bit         did;
        bit         rr0;
        logic [N-1:0] prevg;
        logic [N-1:0] mpend;
        logic [N-1:0] outst;
        logic [N-1:0] rs;
        logic [N-1:0] ed;
        logic [N-1:0] ee;
        int         mlast;
        int         cur;
        int         gcyc;
        int         w;
        bit         mb;
        bit         relp;
        bit         relnow;
        bit         firep;
        bit         errf;
        bit         obs_new;
        bit         exp_new;
        logic [7:0] rdf;
        logic [7:0] exp_rd;

        reset        = 1'b0;
        req_start    = '0;
        req_is_read  = '0;
        req_addr     = '0;
        req_nb_bytes = '0;
        req_wdata    = '0;
        repeat (3) cyc();
        smp();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_addr", m_register_address, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_timeout", timeout, 0);
        cyc();
        reset = 1'b1;
        repeat (2) cyc();

        // Single write from requester 2
        set_req(2, 1'b0, 16'h0010, 10'd1, 8'hA5);
        cyc();
        req_start = 4'b0100;
        smp();
        chk("t1_c0_grant", grant, 0);
        cyc();
        req_start = 4'b0000;
        smp();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_addr", m_register_address, 16'h0010);
        chk("t1_wdata", m_i2c_data, 8'hA5);
        chk("t1_nb", m_nb_of_bytes, 1);
        chk("t1_isread", m_is_read, 0);
        chk("t1_c1_mstart", m_start, 0);
        chk("t1_busy", busy, 1);
        cyc();
        smp();
        chk("t1_c2_mstart", m_start, 1);
        wait_fire("t1");
        chk("t1_done_early", done, 0);
        smp();
        chk("t1_done", done, 4'b0100);
        chk("t1_error", error, 0);
        chk("t1_addr_rel", m_register_address, 16'h0010);
        smp();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_grant", grant, 0);
        chk("t1_done_once", done, 0);

        // Read capture from requester 1
        set_req(1, 1'b1, 16'h0123, 10'd1, 8'h00);
        mst_rd = 8'h3C;
        cyc();
        req_start = 4'b0010;
        smp();
        cyc();
        req_start = 4'b0000;
        wait_fire("t2");
        smp();
        chk("t2_done", done, 4'b0010);
        chk("t2_error", error, 0);
        chk("t2_rdata", rdata, 8'h3C);
        smp();

        // Master error on requester 3 write
        set_req(3, 1'b0, 16'h0200, 10'd2, 8'h5A);
        mst_err = 1;
        mst_rd  = 8'hEE;
        cyc();
        req_start = 4'b1000;
        smp();
        cyc();
        req_start = 4'b0000;
        wait_fire("t3");
        smp();
        chk("t3_error", error, 4'b1000);
        chk("t3_done", done, 0);
        chk("t3_rdata", rdata, 8'h3C);
        mst_err = 0;
        smp();

        // Fairness: all four at once, requester 0 returns after its done
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(i * 3), 10'd1, 8'(i));
        got   = 0;
        did   = 0;
        rr0   = 0;
        prevg = '0;
        for (int c = 0; c < 300 && got < 5; c++) begin
            cyc();
            req_start = (c == 0) ? 4'b1111 : (rr0 ? 4'b0001 : 4'b0000);
            rr0 = 0;
            smp();
            if (grant != 0 && prevg == 0) begin
                ord[got] = oh2i(grant);
                got++;
            end
            if (done[0] && !did) begin
                did = 1;
                rr0 = 1;
            end
            prevg = grant;
        end
        cyc();
        req_start = 4'b0000;
        chk("fair_count", got, 5);
        chk("fair_0", ord[0], 0);
        chk("fair_1", ord[1], 1);
        chk("fair_2", ord[2], 2);
        chk("fair_3", ord[3], 3);
        chk("fair_4", ord[4], 0);
        wait_idle("fair");

`ifdef TOF_ARB_TIMEOUT_EN
        // Watchdog with the master stuck busy
        mst_hold = 1;
        set_req(2, 1'b0, 16'h0044, 10'd1, 8'h11);
        cyc();
        req_start = 4'b0100;
        smp();
        cyc();
        req_start = 4'b0000;
        smp();
        cyc();
        smp();
        chk("to_mstart", m_start, 1);
        repeat (15) smp();
        chk("to_early_timeout", timeout, 0);
        chk("to_early_error", error, 0);
        smp();
        chk("to_timeout", timeout, 1);
        chk("to_error", error, 4'b0100);
        chk("to_done", done, 0);
        smp();
        chk("to_idle", busy, 0);
        chk("to_pulse_once", timeout, 0);
        mst_hold = 0;
        wait_fire("to_drain");
        smp();
        chk("to_late_done", done, 0);
        chk("to_late_error", error, 0);
        smp();
`endif

        // Reset in WAIT_DONE, with requester 1 left pending
        mst_lat = 8;
        set_req(2, 1'b1, 16'h0777, 10'd3, 8'h22);
        cyc();
        req_start = 4'b0100;
        smp();
        cyc();
        req_start = 4'b0000;
        smp();
        cyc();
        smp();
        cyc();
        req_start = 4'b0010;
        smp();
        cyc();
        req_start = 4'b0000;
        smp();
        chk("rs_pre_busy", busy, 1);
        cyc();
        reset = 1'b0;
        smp();
        cyc();
        reset = 1'b1;
        smp();
        chk("rs_grant", grant, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_error", error, 0);
        chk("rs_addr", m_register_address, 0);
        chk("rs_isread", m_is_read, 0);
        chk("rs_nb", m_nb_of_bytes, 0);
        chk("rs_wdata", m_i2c_data, 0);
        chk("rs_rdata", rdata, 0);
        wait_fire("rs");
        smp();
        chk("rs_no_done", done, 0);
        chk("rs_no_error", error, 0);
        chk("rs_pending_clr", grant, 0);
        mst_lat = 0;
        cyc();
        req_start = 4'b1111;
        smp();
        cyc();
        req_start = 4'b0000;
        smp();
        chk("rs_first_idx0", grant, 4'b0001);
        wait_idle("rs");

        // Randomized traffic against the round-robin model
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        mst_rand = 1;
        mpend  = '0;
        outst  = '0;
        prevg  = '0;
        mlast  = N - 1;
        cur    = 0;
        gcyc   = -10;
        mb     = 0;
        relp   = 0;
        firep  = 0;
        errf   = 0;
        rdf    = '0;
        exp_rd = '0;
        for (int t = 0; t < 2600; t++) begin
            cyc();
            rs = '0;
            if (t < 2450) begin
                for (int i = 0; i < N; i++) begin
                    if (!outst[i]) begin
                        if ($urandom_range(0, 5) == 0) begin
                            set_req(i, 1'($urandom), 16'($urandom),
                                    10'($urandom), 8'($urandom));
                            outst[i] = 1'b1;
                            rs[i]    = 1'b1;
                        end
                    end else if (mb && mpend[i] && $urandom_range(0, 3) == 0) begin
                        rs[i] = 1'b1;
                    end
                end
            end
            req_start = rs;
            smp();
            obs_new = (grant != 0) && (prevg == 0);
            exp_new = !mb && (mpend != 0);
            chk("r_grant_event", 32'(obs_new), 32'(exp_new));
            if (exp_new) begin
                w = rr(mpend, mlast);
                chk("r_grant_rr", grant, 32'(4'b0001 << w));
                mpend[w] = 1'b0;
                cur  = w;
                gcyc = t;
                mb   = 1;
            end else if (relp) begin
                mb = 0;
            end
            chk("r_busy", 32'(busy), 32'(mb));
            if (mb) begin
                chk("r_addr", m_register_address, p_addr[cur]);
                chk("r_isread", 32'(m_is_read), 32'(p_rd[cur]));
                chk("r_nb", m_nb_of_bytes, p_nb[cur]);
                chk("r_wdata", m_i2c_data, p_wd[cur]);
            end
            chk("r_mstart", 32'(m_start), 32'(mb && (t == gcyc + 1)));
            ed     = '0;
            ee     = '0;
            relnow = 0;
            if (firep) begin
                if (errf) ee = 4'b0001 << cur;
                else      ed = 4'b0001 << cur;
                if (p_rd[cur]) exp_rd = rdf;
                outst[cur] = 1'b0;
                mlast  = cur;
                relnow = 1;
            end
            chk("r_done", done, ed);
            chk("r_error", error, ee);
            chk("r_rdata", rdata, exp_rd);
            firep = mst_fire;
            errf  = m_error;
            rdf   = m_rdata;
            relp  = relnow;
            mpend = mpend | rs;
            prevg = grant;
        end
        cyc();
        req_start = 4'b0000;
        chk("r_all_served", outst, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
